// File: rtl/dac_tx_pkg.sv
// Shared definitions for the DAC LVDS transmit framer.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
// Contents: mode/state encodings, PRBS7 seed and taps, and a PRBS7 advance function.
package dac_tx_pkg;

    // Requested-mode encoding on the mode input.
    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_TRAIN = 2'd1;
    localparam logic [1:0] MODE_DATA  = 2'd2;
    localparam logic [1:0] MODE_PRBS  = 2'd3;

    // Framer states share the mode encoding so active_mode is the state itself.
    typedef logic [1:0] state_t;
    localparam state_t IDLE_S  = 2'd0;
    localparam state_t TRAIN_S = 2'd1;
    localparam state_t DATA_S  = 2'd2;
    localparam state_t PRBS_S  = 2'd3;

    // PRBS7, x^7 + x^6 + 1: feedback from state bits 6 and 5.
    localparam logic [6:0] PRBS_SEED  = 7'h7F;
    localparam int         PRBS_TAP_A = 6;
    localparam int         PRBS_TAP_B = 5;
    localparam int         PRBS_MAX_W = 32;

    typedef struct packed {
        logic [6:0]            state;
        logic [PRBS_MAX_W-1:0] bits;
    } prbs_step_t;

    // Emits nbits PRBS7 bits (bit 0 first in time) and the state after them.
    // The emitted bit is the oldest state bit, so a 7'h7F seed starts with ones.
    function automatic prbs_step_t prbs7_advance(input logic [6:0] seed, input int nbits);
        prbs_step_t r;
        logic [6:0] s;
        s      = seed;
        r.bits = '0;
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < nbits) begin
                r.bits[i] = s[6];
                s         = {s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
            end
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Synchronous FIFO with registered occupancy, full/empty flags and a flush.
// Latency: a written word is readable the cycle after the write (no fall-through).
// Backpressure: writes are ignored while full; reads are ignored while empty.
// Ports: clk_div_in/io_reset (sync, active-high), flush, wr_vld/wr_dat, rd_rdy/rd_dat,
//        full, empty, level.
module dac_tx_fifo
    import dac_tx_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk_div_in,
    input  logic                       io_reset,
    input  logic                       flush,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic [W-1:0]               rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full   = (count == FULL_LVL);
    assign empty  = (count == '0);
    assign level  = count;
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_div_in) begin
        if (io_reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_div_in) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/dac_lvds_tx_framer.sv
// Multi-lane LVDS DAC framer: picks idle/train/data/PRBS words per lane and marks frames.
// Latency: registered outputs; an accepted sample reaches oserdes_d 2 edges later when buffered empty.
// Backpressure: s_ready = !full in DATA (no bypass when full); outside DATA, s_ready = 1 and words are dropped.
// Ports: clk_div_in, io_reset (sync, active-high), s_data/s_valid/s_ready, mode, train_pattern,
//        oserdes_d, frame_out, active_mode, fifo_level, underflow, underflow_cnt.
// Option: define DAC_LVDS_TX_PRBS_EN to enable PRBS7 content on mode 3 (otherwise mode 3 = IDLE).
module dac_lvds_tx_framer
    import dac_tx_pkg::*;
#(
    parameter int               LANES      = 4,
    parameter int               SER_W      = 4,
    parameter int               FIFO_DEPTH = 8,
    parameter int               FRAME_LEN  = 16,
    parameter logic [SER_W-1:0] IDLE_WORD  = {SER_W{1'b0}}
) (
    input  logic                            clk_div_in,
    input  logic                            io_reset,
    input  logic [LANES*SER_W-1:0]          s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [1:0]                      mode,
    input  logic [SER_W-1:0]                train_pattern,
    output logic [LANES*SER_W-1:0]          oserdes_d,
    output logic [SER_W-1:0]                frame_out,
    output logic [1:0]                      active_mode,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underflow,
    output logic [15:0]                     underflow_cnt
);

    localparam int            DW       = LANES * SER_W;
    localparam int            CW       = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    state_t        state;
    state_t        req_state;
    state_t        state_nxt;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          boundary;
    logic          primed;
    logic          in_data;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_dat;
    logic          starve;
    logic [DW-1:0] word_nxt;

    assign boundary = (frame_cnt == CNT_LAST);
    assign cnt_nxt  = boundary ? '0 : frame_cnt + 1'b1;

    always_comb begin
        req_state = IDLE_S;
        case (mode)
            MODE_TRAIN: req_state = TRAIN_S;
            MODE_DATA:  req_state = DATA_S;
`ifdef DAC_LVDS_TX_PRBS_EN
            MODE_PRBS:  req_state = PRBS_S;
`else
            MODE_PRBS:  req_state = IDLE_S;
`endif
            default:    req_state = IDLE_S;
        endcase
    end

    // Requests only take effect on the edge that starts a new frame.
    assign state_nxt = boundary ? req_state : state;

    // Pop only when the word being loaded is itself a DATA word; a frame that
    // leaves DATA must not consume a sample it will never send.
    assign in_data = (state == DATA_S) && (state_nxt == DATA_S);
    assign fifo_rd = in_data && !fifo_empty;
    assign starve  = in_data && fifo_empty && primed;

    assign s_ready = !io_reset && ((state != DATA_S) || !fifo_full);
    assign fifo_wr = s_valid && s_ready && (state == DATA_S);

    dac_tx_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_div_in (clk_div_in),
        .io_reset   (io_reset),
        .flush      (state != DATA_S),
        .wr_vld     (fifo_wr),
        .wr_dat     (s_data),
        .rd_rdy     (fifo_rd),
        .rd_dat     (fifo_rd_dat),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

`ifdef DAC_LVDS_TX_PRBS_EN
    logic [6:0] prbs_state;
    logic [6:0] prbs_src;
    prbs_step_t prbs_adv;
    logic       prbs_bits_unused;

    // The first PRBS word after entry is generated from the seed itself.
    always_comb begin
        prbs_src = (state == PRBS_S) ? prbs_state : PRBS_SEED;
        prbs_adv = prbs7_advance(prbs_src, SER_W);
    end
    assign prbs_bits_unused = ^prbs_adv.bits;

    always_ff @(posedge clk_div_in) begin
        if (io_reset)                  prbs_state <= PRBS_SEED;
        else if (state_nxt == PRBS_S)  prbs_state <= prbs_adv.state;
    end
`endif

    always_comb begin
        word_nxt = {LANES{IDLE_WORD}};
        case (state_nxt)
            TRAIN_S: word_nxt = {LANES{train_pattern}};
            DATA_S:  if (fifo_rd) word_nxt = fifo_rd_dat;
`ifdef DAC_LVDS_TX_PRBS_EN
            PRBS_S:  word_nxt = {LANES{prbs_adv.bits[SER_W-1:0]}};
`endif
            default: word_nxt = {LANES{IDLE_WORD}};
        endcase
    end

    always_ff @(posedge clk_div_in) begin
        if (io_reset) begin
            state         <= IDLE_S;
            frame_cnt     <= '0;
            oserdes_d     <= '0;
            frame_out     <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
            primed        <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= cnt_nxt;
            oserdes_d <= word_nxt;
            frame_out <= (cnt_nxt == '0) ? {SER_W{1'b1}} : '0;
            underflow <= starve;
            if (starve && (underflow_cnt != 16'hFFFF))
                underflow_cnt <= underflow_cnt + 1'b1;
            if (state_nxt != DATA_S) primed <= 1'b0;
            else if (fifo_rd)        primed <= 1'b1;
        end
    end

    assign active_mode = state;

endmodule

// File: tb/tb_dac_lvds_tx_framer.sv
// Self-checking bench for dac_lvds_tx_framer (LANES=4, SER_W=4, depth 8, 16-cycle frames).
// A queue/sequence-based reference is compared against every output each cycle,
// and directed steps pin the reference with hand-computed words.
module tb_dac_lvds_tx_framer;

    localparam int LANES = 4;
    localparam int SER_W = 4;
    localparam int DEPTH = 8;
    localparam int FLEN  = 16;
`ifdef DAC_LVDS_TX_PRBS_EN
    localparam bit PRBS_ON = 1'b1;
`else
    localparam bit PRBS_ON = 1'b0;
`endif

    logic        clk_div_in = 1'b0;
    logic        io_reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  mode;
    logic [3:0]  train_pattern;
    logic [15:0] oserdes_d;
    logic [3:0]  frame_out;
    logic [1:0]  active_mode;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic [15:0] underflow_cnt;

    always #5 clk_div_in = ~clk_div_in;

    dac_lvds_tx_framer #(
        .LANES      (LANES),
        .SER_W      (SER_W),
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FLEN),
        .IDLE_WORD  (4'h0)
    ) dut (
        .clk_div_in    (clk_div_in),
        .io_reset      (io_reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mode          (mode),
        .train_pattern (train_pattern),
        .oserdes_d     (oserdes_d),
        .frame_out     (frame_out),
        .active_mode   (active_mode),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference ----------------
    bit          prbs_seq [127];
    bit          model_on = 1'b0;
    int          m_cnt, m_mode, m_ucnt, m_pidx;
    bit          m_primed, m_uf;
    logic [15:0] m_word;
    logic [3:0]  m_frame;
    logic [15:0] q [$];

    // PRBS7 output sequence: seven ones, then o[n] = o[n-7] ^ o[n-6].
    initial begin
        for (int n = 0; n < 7; n++) prbs_seq[n] = 1'b1;
        for (int n = 7; n < 127; n++) prbs_seq[n] = prbs_seq[n-7] ^ prbs_seq[n-6];
    end

    always @(posedge clk_div_in) begin : model
        int          req, nxt;
        bit          rdy;
        logic [15:0] w;
        logic [3:0]  nib;
        if (io_reset) begin
            m_cnt = 0; m_mode = 0; m_ucnt = 0; m_pidx = 0;
            m_primed = 0; m_uf = 0; m_word = '0; m_frame = '0;
            q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (mode == 2'd1)                 req = 1;
            else if (mode == 2'd2)            req = 2;
            else if (mode == 2'd3 && PRBS_ON) req = 3;
            else                              req = 0;
            nxt  = (m_cnt == FLEN-1) ? req : m_mode;
            rdy  = (m_mode != 2) || (q.size() < DEPTH);
            w    = 16'h0000;
            m_uf = 1'b0;
            if (nxt == 1) begin
                w = {4{train_pattern}};
            end else if (nxt == 2 && m_mode == 2) begin
                if (q.size() > 0) begin
                    w = q.pop_front();
                    m_primed = 1'b1;
                end else if (m_primed) begin
                    m_uf = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end else if (nxt == 3) begin
                if (m_mode != 3) m_pidx = 0;
                for (int k = 0; k < 4; k++) nib[k] = prbs_seq[(m_pidx + k) % 127];
                w = {4{nib}};
                m_pidx = (m_pidx + 4) % 127;
            end
            if (m_mode == 2 && s_valid && rdy) q.push_back(s_data);
            if (m_mode != 2) q.delete();
            if (nxt != 2) m_primed = 1'b0;
            m_word  = w;
            m_cnt   = (m_cnt + 1) % FLEN;
            m_frame = (m_cnt == 0) ? 4'hF : 4'h0;
            m_mode  = nxt;
        end
    end

    always @(negedge clk_div_in) begin
        if (model_on) begin
            chk("cyc_oserdes_d", oserdes_d, m_word);
            chk("cyc_frame_out", frame_out, m_frame);
            chk("cyc_active_mode", active_mode, m_mode);
            chk("cyc_fifo_level", fifo_level, q.size());
            chk("cyc_underflow", underflow, m_uf);
            chk("cyc_underflow_cnt", underflow_cnt, m_ucnt);
            chk("cyc_s_ready", s_ready, io_reset ? 0 : ((m_mode != 2 || q.size() < DEPTH) ? 1 : 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_div_in);
        #1;
    endtask

    task automatic wait_cnt(input int c);
        int n = 0;
        tick();
        while (m_cnt != c && n < 4*FLEN) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stale;
        io_reset = 1'b1; mode = 2'd0; s_valid = 1'b0; s_data = '0; train_pattern = '0;
        tick(); tick(); tick();
        chk("rst_oserdes_d", oserdes_d, 16'h0000);
        chk("rst_frame_out", frame_out, 4'h0);
        chk("rst_active_mode", active_mode, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_underflow_cnt", underflow_cnt, 0);
        chk("rst_s_ready", s_ready, 0);
        io_reset = 1'b0;

        // IDLE: frame marker once per frame, idle word everywhere
        wait_cnt(5);
        wait_cnt(0);
        chk("idle_frame_mark", frame_out, 4'hF);
        chk("idle_word", oserdes_d, 16'h0000);
        tick();
        chk("idle_frame_gap", frame_out, 4'h0);

        // TRAIN requested mid-frame, applied at the next boundary
        wait_cnt(5);
        mode = 2'd1; train_pattern = 4'hA;
        wait_cnt(15);
        chk("train_pending_mode", active_mode, 0);
        chk("train_pending_word", oserdes_d, 16'h0000);
        tick();
        chk("train_mode", active_mode, 1);
        chk("train_word", oserdes_d, 16'hAAAA);
        chk("train_frame_mark", frame_out, 4'hF);
        train_pattern = 4'h5;
        tick();
        chk("train_follow", oserdes_d, 16'h5555);

        // DATA burst of 8 words, then starvation
        mode = 2'd2;
        wait_cnt(0);
        chk("data_mode", active_mode, 2);
        tick(); tick();
        chk("data_unprimed_no_uf", underflow, 0);
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            tick();
            if (i == 1) begin
                chk("data_first_level", fifo_level, 1);
                chk("data_first_not_out", oserdes_d, 16'h0000);
            end else begin
                chk($sformatf("data_word_%0d", i-1), oserdes_d, 16'(i-1));
            end
        end
        s_valid = 1'b0;
        tick();
        chk("data_word_8", oserdes_d, 16'h0008);
        chk("data_word_8_no_uf", underflow, 0);
        tick();
        chk("uf_pulse_1", underflow, 1);
        chk("uf_cnt_1", underflow_cnt, 1);
        tick();
        chk("uf_cnt_2", underflow_cnt, 2);

        // reset in the middle of a burst discards buffered words
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'hA0 + 16'(i);
            tick();
        end
        s_valid = 1'b0; io_reset = 1'b1;
        tick();
        chk("mid_rst_oserdes_d", oserdes_d, 16'h0000);
        chk("mid_rst_fifo_level", fifo_level, 0);
        chk("mid_rst_uf_cnt", underflow_cnt, 0);
        chk("mid_rst_mode", active_mode, 0);
        io_reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid = (i < 5); s_data = 16'hBEEF;
            tick();
            if (oserdes_d !== 16'h0000) stale++;
        end
        s_valid = 1'b0;
        chk("post_rst_stale_words", stale, 0);

        // mode 3
        mode = 2'd3;
        wait_cnt(0);
`ifdef DAC_LVDS_TX_PRBS_EN
        chk("prbs_mode", active_mode, 3);
        chk("prbs_w0", oserdes_d, 16'hFFFF);
        tick(); chk("prbs_w1", oserdes_d, 16'h7777);
        tick(); chk("prbs_w2", oserdes_d, 16'h0000);
        tick(); chk("prbs_w3", oserdes_d, 16'h2222);
        repeat (124) tick();
        chk("prbs_period_w127", oserdes_d, 16'hFFFF);
        tick();
        chk("prbs_period_w128", oserdes_d, 16'h7777);
`else
        chk("prbs_off_mode", active_mode, 0);
        chk("prbs_off_word", oserdes_d, 16'h0000);
        tick();
        chk("prbs_off_word_next", oserdes_d, 16'h0000);
`endif

        // underflow counter saturation
        mode = 2'd2;
        wait_cnt(0);
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        s_valid = 1'b0;
        tick();
        chk("sat_prime_word", oserdes_d, 16'h1234);
        repeat (65534) tick();
        chk("sat_cnt_fffe", underflow_cnt, 16'hFFFE);
        tick();
        chk("sat_cnt_ffff", underflow_cnt, 16'hFFFF);
        tick();
        chk("sat_cnt_hold", underflow_cnt, 16'hFFFF);
        chk("sat_uf_pulse", underflow, 1);
        tick();
        chk("sat_cnt_hold2", underflow_cnt, 16'hFFFF);
        chk("sat_uf_pulse2", underflow, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
